// File: rtl/pi_ctl_sequencer.sv
// Slews the live PI code toward the CDR target with bounded, shortest-path steps and fans it out to
// N_PHASES offset PIs. Optional lock detector is enabled by defining PI_SEQ_LOCK_DET_EN.
module pi_ctl_sequencer #(
   parameter int N_PI_BITS = 9,
   parameter int N_PHASES  = 4,
   parameter int MAX_STEP  = 4,
   parameter int UPD_DIV   = 2,
   parameter int LOCK_TOL  = 2,
   parameter int LOCK_CNT  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   // target_valid is a single-cycle qualifier with no back-pressure: target_code is consumed
   // on every cycle target_valid is high (ignored while in EXT).
   input  logic [N_PI_BITS-1:0]          target_code,
   input  logic                          target_valid,
   input  logic                          en_ext_pi_ctl,
   input  logic [N_PI_BITS-1:0]          ext_pi_ctl,
   input  logic [N_PHASES*N_PI_BITS-1:0] pi_offset,
   output logic [N_PHASES*N_PI_BITS-1:0] pi_ctl,
   output logic [N_PI_BITS-1:0]          cur_code,
   output logic                          step_active,
   output logic                          locked,
   output logic [7:0]                    lock_lost_cnt,
   output logic [1:0]                    fsm_state
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] SLEW = 2'b01;
   localparam logic [1:0] EXT  = 2'b10;

   localparam int TICK_W = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
   localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(UPD_DIV - 1);
   localparam logic [N_PI_BITS-1:0] HALF_TURN = {1'b1, {(N_PI_BITS-1){1'b0}}};
   localparam logic signed [N_PI_BITS:0] STEP_POS = (N_PI_BITS+1)'(MAX_STEP);
   localparam logic signed [N_PI_BITS:0] STEP_NEG = -((N_PI_BITS+1)'(MAX_STEP));

   logic [1:0]                    state_q, state_d;
   logic [N_PI_BITS-1:0]          cur_q, cur_d;
   logic [N_PI_BITS-1:0]          tgt_q, tgt_d;
   logic [TICK_W-1:0]             tick_q, tick_d;
   logic [N_PHASES*N_PI_BITS-1:0] pi_q, pi_d;

   logic                          tick_fire;
   logic [N_PI_BITS-1:0]          diff;
   logic signed [N_PI_BITS:0]     diff_s;
   logic signed [N_PI_BITS:0]     step_s;
   logic [N_PI_BITS-1:0]          step_next;

   assign tick_fire = (tick_q == TICK_LAST);
   assign diff      = tgt_q - cur_q;

   // An exact half turn has no shortest direction; it is taken as a positive move.
   always_comb begin
      if (diff == HALF_TURN) diff_s = {1'b0, diff};
      else                   diff_s = {diff[N_PI_BITS-1], diff};
      if (diff_s > STEP_POS)      step_s = STEP_POS;
      else if (diff_s < STEP_NEG) step_s = STEP_NEG;
      else                        step_s = diff_s;
      step_next = N_PI_BITS'({1'b0, cur_q} + $unsigned(step_s));
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      tick_d  = tick_q;
      if (en_ext_pi_ctl) begin
         state_d = EXT;
         cur_d   = ext_pi_ctl;
         tick_d  = '0;
      end else if (state_q == EXT) begin
         state_d = IDLE;
         tgt_d   = cur_q;
      end else begin
         tick_d = tick_fire ? '0 : tick_q + 1'b1;
         if (target_valid) tgt_d = target_code;
         case (state_q)
            IDLE: if (tgt_q != cur_q) state_d = SLEW;
            SLEW: begin
               if (tick_fire) begin
                  cur_d = step_next;
                  if (step_next == tgt_q) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pi_d = '0;
      for (int i = 0; i < N_PHASES; i++) begin
         pi_d[i*N_PI_BITS +: N_PI_BITS] = cur_q + pi_offset[i*N_PI_BITS +: N_PI_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         tick_q  <= '0;
         pi_q    <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         tick_q  <= tick_d;
         pi_q    <= pi_d;
      end
   end

`ifdef PI_SEQ_LOCK_DET_EN
   localparam int LCNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_CNT);

   logic [LCNT_W-1:0]    lock_cnt_q, lock_cnt_d;
   logic                 locked_q, locked_d;
   logic [7:0]           lost_q, lost_d;
   logic [N_PI_BITS-1:0] err, err_abs;
   logic                 in_tol;

   assign err     = target_code - cur_q;
   assign err_abs = err[N_PI_BITS-1] ? (~err + 1'b1) : err;
   assign in_tol  = (err_abs <= N_PI_BITS'(LOCK_TOL));

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      lost_d     = lost_q;
      if (en_ext_pi_ctl) begin
         lock_cnt_d = '0;
         locked_d   = 1'b0;
      end else if ((state_q != EXT) && target_valid) begin
         if (in_tol) begin
            if (lock_cnt_q != LCNT_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
            if (lock_cnt_d == LCNT_MAX) locked_d = 1'b1;
         end else begin
            lock_cnt_d = '0;
            if (locked_q) begin
               locked_d = 1'b0;
               if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         lost_q     <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         lost_q     <= lost_d;
      end
   end

   assign locked        = locked_q;
   assign lock_lost_cnt = lost_q;
`else
   assign locked        = 1'b0;
   assign lock_lost_cnt = 8'd0;
`endif

   assign pi_ctl      = pi_q;
   assign cur_code    = cur_q;
   assign step_active = (state_q == SLEW);
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_pi_ctl_sequencer.sv
// Directed bench for pi_ctl_sequencer: an arithmetic model checked every cycle, plus literal
// expectations from hand-worked scenarios (slew, wrap, tie, override, lock, reset mid-slew).
module tb_pi_ctl_sequencer;
   localparam int NB  = 9;
   localparam int NP  = 4;
   localparam int MOD = 512;
   localparam int MAXS = 4;
   localparam int DIV = 2;
   localparam int TOL = 2;
   localparam int LCN = 64;
`ifdef PI_SEQ_LOCK_DET_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NB-1:0]     target_code = '0;
   logic              target_valid = 1'b0;
   logic              en_ext_pi_ctl = 1'b0;
   logic [NB-1:0]     ext_pi_ctl = '0;
   logic [NP*NB-1:0]  pi_offset;
   logic [NP*NB-1:0]  pi_ctl;
   logic [NB-1:0]     cur_code;
   logic              step_active;
   logic              locked;
   logic [7:0]        lock_lost_cnt;
   logic [1:0]        fsm_state;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   pi_ctl_sequencer dut (
      .clk(clk), .rst(rst), .target_code(target_code), .target_valid(target_valid),
      .en_ext_pi_ctl(en_ext_pi_ctl), .ext_pi_ctl(ext_pi_ctl), .pi_offset(pi_offset),
      .pi_ctl(pi_ctl), .cur_code(cur_code), .step_active(step_active), .locked(locked),
      .lock_lost_cnt(lock_lost_cnt), .fsm_state(fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // mode: 0 idle, 1 slewing, 2 external override
   typedef struct packed {
      int cur; int tgt; int tick; int mode; int lcnt; int lockd; int lost;
   } mdl_t;
   mdl_t m;
   int   m_pi [NP];

   function automatic int wrap_signed(input int v);
      int r;
      r = ((v % MOD) + MOD) % MOD;
      if (r >= MOD/2) r -= MOD;
      return r;
   endfunction

   function automatic mdl_t model_next(input mdl_t s, input bit r, input bit tv, input int tc,
                                       input bit en, input int ext);
      mdl_t n;
      int d, st, e;
      bit fire;
      n = s;
      if (r) return '0;
      if (en) begin
         n.mode = 2; n.cur = ext; n.tick = 0; n.lcnt = 0; n.lockd = 0;
         return n;
      end
      if (s.mode == 2) begin
         n.mode = 0; n.tgt = s.cur;
         return n;
      end
      fire   = (s.tick == DIV-1);
      n.tick = fire ? 0 : s.tick + 1;
      if (tv) begin
         n.tgt = tc;
         if (LOCK_ON) begin
            e = wrap_signed(tc - s.cur);
            if (e < 0) e = -e;
            if (e <= TOL) begin
               n.lcnt = (s.lcnt < LCN) ? s.lcnt + 1 : LCN;
               if (n.lcnt == LCN) n.lockd = 1;
            end else begin
               n.lcnt = 0;
               if (s.lockd == 1) begin
                  n.lockd = 0;
                  n.lost  = (s.lost < 255) ? s.lost + 1 : 255;
               end
            end
         end
      end
      if (s.mode == 1 && fire) begin
         d = wrap_signed(s.tgt - s.cur);
         if (d == -MOD/2) d = MOD/2;
         st = (d > MAXS) ? MAXS : (d < -MAXS) ? -MAXS : d;
         n.cur = (s.cur + st + MOD) % MOD;
         if (n.cur == s.tgt) n.mode = 0;
      end else if (s.mode == 0 && s.tgt != s.cur) begin
         n.mode = 1;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m <= model_next(m, rst, target_valid, int'(target_code), en_ext_pi_ctl, int'(ext_pi_ctl));
      for (int i = 0; i < NP; i++)
         m_pi[i] <= rst ? 0 : (m.cur + int'(pi_offset[i*NB +: NB])) % MOD;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard compare, every cycle once reset has been applied
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cur_code", int'(cur_code), m.cur);
         check("step_active", int'(step_active), (m.mode == 1) ? 1 : 0);
         check("locked", int'(locked), m.lockd);
         check("lock_lost_cnt", int'(lock_lost_cnt), m.lost);
         for (int i = 0; i < NP; i++)
            check($sformatf("pi_ctl[%0d]", i), int'(pi_ctl[i*NB +: NB]), m_pi[i]);
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic send_target(input int code);
      target_code  = NB'(code);
      target_valid = 1'b1;
      cyc(1);
      target_valid = 1'b0;
   endtask

   task automatic wait_cur(input string name, input int v, input int budget);
      int k;
      k = 0;
      while (int'(cur_code) != v && k < budget) begin
         cyc(1);
         k++;
      end
      check(name, int'(cur_code), v);
   endtask

   initial begin
      pi_offset = {9'd511, 9'd3, 9'd0, 9'd0};
      cyc(2);
      cmp_en = 1'b1;
      check("reset cur_code", int'(cur_code), 0);
      check("reset step_active", int'(step_active), 0);
      check("reset pi_ctl", int'(pi_ctl), 0);
      check("reset locked", int'(locked), 0);
      rst = 1'b0;

      // slew 0 -> 10
      send_target(10);
      cyc(3);
      check("slew first", int'(cur_code), 4);
      check("slew active", int'(step_active), 1);
      cyc(2);
      check("slew second", int'(cur_code), 8);
      cyc(2);
      check("slew third", int'(cur_code), 10);
      check("slew done", int'(step_active), 0);
      cyc(4);
      check("slew hold", int'(cur_code), 10);

      // wrap 510 -> 3 via the positive path
      do_reset();
      send_target(510);
      cyc(3);
      check("wrap back", int'(cur_code), 510);
      send_target(3);
      wait_cur("wrap 2", 2, 20);
      cyc(1);
      wait_cur("wrap 3", 3, 3);
      cyc(2);
      check("wrap idle", int'(step_active), 0);

      // half-turn tie is positive
      do_reset();
      send_target(256);
      cyc(3);
      check("tie first", int'(cur_code), 4);
      cyc(2);
      check("tie second", int'(cur_code), 8);

      // external override mid-slew
      en_ext_pi_ctl = 1'b1;
      ext_pi_ctl    = 9'd100;
      pi_offset[1*NB +: NB] = 9'd500;
      cyc(1);
      check("ext cur", int'(cur_code), 100);
      cyc(1);
      check("ext pi1", int'(pi_ctl[1*NB +: NB]), 88);
      check("ext locked", int'(locked), 0);
      check("ext no slew", int'(step_active), 0);
      en_ext_pi_ctl = 1'b0;
      cyc(1);
      send_target(100);
      cyc(6);
      check("post-ext cur", int'(cur_code), 100);
      check("post-ext idle", int'(step_active), 0);

      // lock detect
      do_reset();
      for (int i = 0; i < LCN; i++) begin
         send_target(i & 1);
         if (i == LCN-2) check("lock 63", int'(locked), 0);
         if (i == LCN-1) check("lock 64", int'(locked), LOCK_ON ? 1 : 0);
         cyc(1);
      end
      send_target(10);
      check("lock lost", int'(locked), 0);
      check("lock lost cnt", int'(lock_lost_cnt), LOCK_ON ? 1 : 0);
      cyc(10);

      // reset mid-slew
      do_reset();
      send_target(200);
      cyc(7);
      check("mid-slew cur", int'(cur_code), 12);
      rst = 1'b1;
      cyc(1);
      check("rst cur", int'(cur_code), 0);
      check("rst active", int'(step_active), 0);
      check("rst pi_ctl", int'(pi_ctl), 0);
      check("rst lost", int'(lock_lost_cnt), 0);
      rst = 1'b0;
      cyc(10);
      check("rst no step", int'(cur_code), 0);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
